// File: rtl/vga_timing_gen_if.sv
// Video timing bundle driven by the raster generator: sync levels,
// active-video flag, pixel coordinates and line/frame strobes.
interface vga_timing_gen_if #(
    parameter int unsigned XW = 10,
    parameter int unsigned YW = 10
);
    logic          o_hsync;
    logic          o_vsync;
    logic          o_active;
    logic [XW-1:0] o_x;
    logic [YW-1:0] o_y;
    logic          o_line_start;
    logic          o_frame_start;

    modport master (
        output o_hsync, o_vsync, o_active, o_x, o_y, o_line_start, o_frame_start
    );

    modport slave (
        input o_hsync, o_vsync, o_active, o_x, o_y, o_line_start, o_frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator. Joint h/v counters advance on the
// pixel enable; every output is registered and decoded from the counters'
// next values so outputs describe the position held after each edge.
module vga_timing_gen #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter bit          HS_POL    = 1'b1,
    parameter bit          VS_POL    = 1'b1,
    parameter int unsigned XW        = 10,
    parameter int unsigned YW        = 10
) (
    input  logic             clk,
    input  logic             i_sclr,
    input  logic             i_px_clk,
    vga_timing_gen_if.master vid
);
    localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_VISIBLE + H_FRONT;
    localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_VISIBLE + V_FRONT;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);
    localparam int unsigned H_ACT0  = H_SYNC + H_BACK;
    localparam int unsigned H_ACT1  = H_ACT0 + H_VISIBLE;
    localparam int unsigned V_ACT0  = V_SYNC + V_BACK;
    localparam int unsigned V_ACT1  = V_ACT0 + V_VISIBLE;

    logic [HW-1:0] r_h;
    logic [VW-1:0] r_v;
    logic [HW-1:0] w_h_nxt;
    logic [VW-1:0] w_v_nxt;
    logic          w_h_wrap;
    logic          w_v_wrap;
    logic [31:0]   w_hc;
    logic [31:0]   w_vc;
    logic          w_hs;
    logic          w_vs;
    logic          w_act;
    logic [XW-1:0] w_x;
    logic [YW-1:0] w_y;

    logic          r_hsync;
    logic          r_vsync;
    logic          r_active;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic          r_line_start;
    logic          r_frame_start;

    // Next counter position assuming the pixel enable is asserted
    always_comb begin
        w_h_wrap = (r_h == HW'(H_TOTAL - 1));
        w_v_wrap = (r_v == VW'(V_TOTAL - 1));
        w_h_nxt  = w_h_wrap ? '0 : r_h + 1'b1;
        w_v_nxt  = r_v;
        if (w_h_wrap) begin
            w_v_nxt = w_v_wrap ? '0 : r_v + 1'b1;
        end
    end

    // Region decode of the next position
    always_comb begin
        w_hc  = 32'(w_h_nxt);
        w_vc  = 32'(w_v_nxt);
        w_hs  = (w_hc < H_SYNC) ? HS_POL : ~HS_POL;
        w_vs  = (w_vc < V_SYNC) ? VS_POL : ~VS_POL;
        w_act = (w_hc >= H_ACT0) && (w_hc < H_ACT1) &&
                (w_vc >= V_ACT0) && (w_vc < V_ACT1);
        w_x   = '0;
        w_y   = '0;
        if (w_act) begin
            w_x = XW'(w_hc - H_ACT0);
            w_y = YW'(w_vc - V_ACT0);
        end
    end

    // Counter and output registers; strobes default low, levels hold when idle
    always_ff @(posedge clk) begin
        if (i_sclr) begin
            r_h           <= '0;
            r_v           <= '0;
            r_hsync       <= HS_POL;
            r_vsync       <= VS_POL;
            r_active      <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            if (i_px_clk) begin
                r_h           <= w_h_nxt;
                r_v           <= w_v_nxt;
                r_hsync       <= w_hs;
                r_vsync       <= w_vs;
                r_active      <= w_act;
                r_x           <= w_x;
                r_y           <= w_y;
                r_line_start  <= w_h_wrap;
                r_frame_start <= w_h_wrap & w_v_wrap;
            end
        end
    end

    assign vid.o_hsync       = r_hsync;
    assign vid.o_vsync       = r_vsync;
    assign vid.o_active      = r_active;
    assign vid.o_x           = r_x;
    assign vid.o_y           = r_y;
    assign vid.o_line_start  = r_line_start;
    assign vid.o_frame_start = r_frame_start;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench: a default-timing instance and a tiny inverted-polarity instance
// share clk/reset/enable; both are checked every cycle against a model that
// derives the raster position from the number of enables since reset.
module tb_vga_timing_gen;
    logic clk = 1'b0;
    logic i_sclr;
    logic i_px_clk;

    vga_timing_gen_if #(.XW(10), .YW(10)) vid_d ();
    vga_timing_gen_if #(.XW(2),  .YW(2))  vid_s ();

    vga_timing_gen dut_d (
        .clk      (clk),
        .i_sclr   (i_sclr),
        .i_px_clk (i_px_clk),
        .vid      (vid_d.master)
    );

    vga_timing_gen #(
        .H_VISIBLE (4), .H_FRONT (1), .H_SYNC (2), .H_BACK (1),
        .V_VISIBLE (3), .V_FRONT (1), .V_SYNC (1), .V_BACK (1),
        .HS_POL    (1'b0), .VS_POL (1'b0),
        .XW        (2), .YW (2)
    ) dut_s (
        .clk      (clk),
        .i_sclr   (i_sclr),
        .i_px_clk (i_px_clk),
        .vid      (vid_s.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          hs, vs, act, ls, fs;
        int unsigned x, y;
    } exp_t;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    longint      n        = 0;   // enables since last reset
    longint      cyc      = 0;
    longint      last_ls  = -1;
    longint      last_fs  = -1;
    int unsigned exp_ls_per = 0; // 0 = period not tracked
    int unsigned exp_fs_per = 0;

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t model(input longint cnt, input bit strobe_ok,
                                   input int unsigned hv, hf, hs, hb,
                                   input int unsigned vv, vf, vs, vb,
                                   input bit hp, input bit vp);
        exp_t        e;
        int unsigned ht, vt, h, v;
        ht    = hv + hf + hs + hb;
        vt    = vv + vf + vs + vb;
        h     = int'(cnt % ht);
        v     = int'((cnt / ht) % vt);
        e.hs  = (h < hs) ? hp : !hp;
        e.vs  = (v < vs) ? vp : !vp;
        e.act = (h >= hs + hb) && (h < hs + hb + hv) && (v >= vs + vb) && (v < vs + vb + vv);
        e.x   = e.act ? h - (hs + hb) : 0;
        e.y   = e.act ? v - (vs + vb) : 0;
        e.ls  = strobe_ok && (h == 0);
        e.fs  = strobe_ok && (cnt % (ht * vt) == 0);
        return e;
    endfunction

    task automatic step(input bit sclr, input bit px);
        exp_t ed, es;
        i_sclr   = sclr;
        i_px_clk = px;
        @(posedge clk);
        cyc++;
        if (sclr)    n = 0;
        else if (px) n++;
        #1;
        ed = model(n, px && !sclr, 640, 16, 96, 48, 480, 10, 2, 33, 1'b1, 1'b1);
        es = model(n, px && !sclr, 4, 1, 2, 1, 3, 1, 1, 1, 1'b0, 1'b0);
        chk("d_hsync",  vid_d.o_hsync,       ed.hs);
        chk("d_vsync",  vid_d.o_vsync,       ed.vs);
        chk("d_active", vid_d.o_active,      ed.act);
        chk("d_x",      vid_d.o_x,           ed.x);
        chk("d_y",      vid_d.o_y,           ed.y);
        chk("d_ls",     vid_d.o_line_start,  ed.ls);
        chk("d_fs",     vid_d.o_frame_start, ed.fs);
        chk("s_hsync",  vid_s.o_hsync,       es.hs);
        chk("s_vsync",  vid_s.o_vsync,       es.vs);
        chk("s_active", vid_s.o_active,      es.act);
        chk("s_x",      vid_s.o_x,           es.x);
        chk("s_y",      vid_s.o_y,           es.y);
        chk("s_ls",     vid_s.o_line_start,  es.ls);
        chk("s_fs",     vid_s.o_frame_start, es.fs);
        if (exp_ls_per != 0 && vid_d.o_line_start) begin
            if (last_ls >= 0) chk("d_ls_period", int'(cyc - last_ls), exp_ls_per);
            last_ls = cyc;
        end
        if (exp_fs_per != 0 && vid_s.o_frame_start) begin
            if (last_fs >= 0) chk("s_fs_period", int'(cyc - last_fs), exp_fs_per);
            last_fs = cyc;
        end
    endtask

    task automatic restart(input int unsigned ls_per, input int unsigned fs_per);
        exp_ls_per = 0;
        exp_fs_per = 0;
        step(1'b1, 1'b0);
        chk("rst_d_hsync", vid_d.o_hsync, 1);
        chk("rst_d_vsync", vid_d.o_vsync, 1);
        chk("rst_s_hsync", vid_s.o_hsync, 0);
        chk("rst_s_vsync", vid_s.o_vsync, 0);
        chk("rst_d_active", vid_d.o_active, 0);
        last_ls    = -1;
        last_fs    = -1;
        exp_ls_per = ls_per;
        exp_fs_per = fs_per;
    endtask

    initial begin
        bit     seen_act, seen_hlow, seen_vlow;
        longint at_act, at_hlow, at_vlow;
        i_sclr   = 1'b1;
        i_px_clk = 1'b0;

        // Continuous enable from reset: first h-sync/v-sync ends, first active pixel
        restart(800, 48);
        seen_act  = 0; seen_hlow = 0; seen_vlow = 0;
        at_act    = 0; at_hlow   = 0; at_vlow   = 0;
        for (int i = 0; i < 28300; i++) begin
            step(1'b0, 1'b1);
            if (!seen_hlow && !vid_d.o_hsync) begin seen_hlow = 1; at_hlow = n; end
            if (!seen_vlow && !vid_d.o_vsync) begin seen_vlow = 1; at_vlow = n; end
            if (!seen_act && vid_d.o_active) begin
                seen_act = 1;
                at_act   = n;
                chk("d_first_x", vid_d.o_x, 0);
                chk("d_first_y", vid_d.o_y, 0);
            end
        end
        chk("d_hsync_len",  int'(at_hlow), 96);
        chk("d_vsync_len",  int'(at_vlow), 1600);
        chk("d_first_act",  int'(at_act),  35 * 800 + 144);

        // Mid-frame reset together with an enable: no strobe, back to origin
        step(1'b1, 1'b1);
        chk("mid_rst_d_ls", vid_d.o_line_start, 0);
        chk("mid_rst_d_fs", vid_d.o_frame_start, 0);

        // Enable every third clock: periods scale by three
        restart(2400, 144);
        for (int i = 0; i < 5200; i++) step(1'b0, (i % 3) == 2);

        // Random enable pattern with rare resets
        exp_ls_per = 0;
        exp_fs_per = 0;
        for (int i = 0; i < 30000; i++) begin
            step(($urandom % 3000) == 0, ($urandom % 4) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
